capp_sequencer: RTL and testbench

- Command-driven controller for the content-addressable parallel processor array (compare, cells and tags units).
- Accepts one opcode at a time over a valid/ready handshake and drives the array's control lines: comparand, mask, perform_search, set, select_first and write_lines.
- Generates the wait cycles each operation needs.
- Returns search/select status and read data over a valid/ready response channel.
- Sits between the host/program source and the array.

---
 rtl/capp_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_capp_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_sequencer.sv
// Command sequencer for the content-addressable parallel processor array.
// Turns one opcode at a time into array control strobes and a status/data response.
module capp_sequencer #(
  parameter int unsigned SEARCH_LAT = 2,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned WRITE_CYC  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic [31:0] comparand,
  output logic [31:0] mask,
  output logic        perform_search,
  output logic        set,
  output logic        select_first,
  output logic [63:0] write_lines,
  input  logic [31:0] read_lines,
  input  logic        some,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_some,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 64;
  localparam int unsigned CW = 4;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_SEARCH = 3'd2;
  localparam logic [2:0] OP_SELECT = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_READ   = 3'd5;

  // CAPTURE is the sampling step on the edge into RESP, so it never holds the state register.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STROBE  = 3'd1,
    WAIT    = 3'd2,
    SETTAG  = 3'd3,
    RESP    = 3'd5
  } state_t;

  state_t          state;
  logic [2:0]      op;
  logic [CW-1:0]   cnt;

  // Each masked bit drives exactly one of its write-1 / write-0 lines.
  function automatic logic [LW-1:0] encode_write(input logic [DW-1:0] d, input logic [DW-1:0] m);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DW); i++) begin
      r[2*i]   = d[i] & m[i];
      r[2*i+1] = ~d[i] & m[i];
    end
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      op             <= OP_NOP;
      cnt            <= '0;
      cmd_ready      <= 1'b0;
      comparand      <= '0;
      mask           <= '0;
      perform_search <= 1'b0;
      set            <= 1'b0;
      select_first   <= 1'b0;
      write_lines    <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_some       <= 1'b0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      perform_search <= 1'b0;
      set            <= 1'b0;
      select_first   <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op       <= cmd_op;
            rsp_data <= '0;
            rsp_some <= 1'b0;
            rsp_err  <= 1'b0;
            case (cmd_op)
              OP_NOP: ;
              OP_LOAD: begin
                comparand <= cmd_data;
                mask      <= cmd_mask;
              end
              OP_SEARCH: begin
                perform_search <= 1'b1;
                state          <= STROBE;
                cmd_ready      <= 1'b0;
                busy           <= 1'b1;
              end
              OP_SELECT: begin
                select_first <= 1'b1;
                state        <= STROBE;
                cmd_ready    <= 1'b0;
                busy         <= 1'b1;
              end
              OP_WRITE: begin
                write_lines <= encode_write(cmd_data, cmd_mask);
                cnt         <= CW'(WRITE_CYC - 1);
                state       <= WAIT;
                cmd_ready   <= 1'b0;
                busy        <= 1'b1;
              end
              OP_READ: begin
                cnt       <= CW'(READ_LAT - 1);
                state     <= WAIT;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              default: begin
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
            endcase
          end
        end
        STROBE: begin
          if (op == OP_SEARCH) begin
            cnt   <= CW'(SEARCH_LAT - 1);
            state <= WAIT;
          end else begin
            rsp_some  <= some;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (op == OP_SEARCH) begin
            set   <= 1'b1;
            state <= SETTAG;
          end else if (op == OP_READ) begin
            rsp_data  <= read_lines;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            write_lines <= '0;
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
          end
        end
        SETTAG: begin
          rsp_some  <= some;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capp_sequencer.sv
// Scoreboard bench for capp_sequencer: expected responses queued at issue, compared on rsp_valid.
module tb_capp_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic [31:0] comparand;
  logic [31:0] mask;
  logic        perform_search;
  logic        set;
  logic        select_first;
  logic [63:0] write_lines;
  logic [31:0] read_lines = '0;
  logic        some = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_some;
  logic        rsp_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        some;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  int   checks = 0;
  int   failures = 0;

  capp_sequencer #(.SEARCH_LAT(2), .READ_LAT(1), .WRITE_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .comparand(comparand), .mask(mask), .perform_search(perform_search),
    .set(set), .select_first(select_first), .write_lines(write_lines),
    .read_lines(read_lines), .some(some), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_some(rsp_some),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Strobes must never overlap.
  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if ((32'(perform_search) + 32'(set) + 32'(select_first)) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive: ps=%b set=%b sel=%b, required at most one high",
                 perform_search, set, select_first);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then presents the command for one accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] m);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_mask  = m;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    cmd_mask  = '0;
  endtask

  // Called in cycle 1 after accept; returns the cycle index where rsp_valid was seen.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      step();
      cyc++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, cyc);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({cmd_ready, comparand, mask, perform_search, set, select_first, write_lines,
         rsp_valid, rsp_data, rsp_some, rsp_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b cmp=%h mask=%h wl=%h rv=%b busy=%b, required all 0",
               cmd_ready, comparand, mask, write_lines, rsp_valid, busy);
    end
    RST = 1'b0;
    step();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_load();
    issue(3'd1, 32'hA5A5_0000, 32'hFFFF_0000);
    checks++;
    if ({comparand, mask, rsp_valid, cmd_ready} !== {32'hA5A5_0000, 32'hFFFF_0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL load: cmp=%h mask=%h rv=%b ready=%b, required A5A50000 FFFF0000 0 1",
               comparand, mask, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_search(input logic s);
    logic [3:0] want;
    some = s;
    exp_q.push_back('{data: 32'h0, some: s, err: 1'b0});
    issue(3'd2, 32'h0, 32'h0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      want = {cyc == 1, cyc == 4, 1'b0, cyc == 5};
      checks++;
      if ({perform_search, set, select_first, rsp_valid} !== want) begin
        failures++;
        $display("FAIL search_timing c%0d: {ps,set,sel,rv}=%b, required %b",
                 cyc, {perform_search, set, select_first, rsp_valid}, want);
      end
      if (cyc < 5) step();
    end
    if (rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL search_rsp: data=%h some=%b err=%b, required %h %b %b",
                 rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL search_handshake: rv=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [63:0] want;
    issue(3'd4, 32'h0000_0003, 32'h0000_0006);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      want = (cyc <= 2) ? 64'h24 : 64'h0;
      checks++;
      if (write_lines !== want || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL write_lines c%0d: wl=%h rv=%b, required %h 0", cyc, write_lines, rsp_valid, want);
      end
      if (cyc == 3) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL write_done: ready=%b, required 1", cmd_ready);
        end
      end
      step();
    end
  endtask

  task automatic test_read_stall();
    int cyc;
    read_lines = 32'hDEAD_BEEF;
    exp_q.push_back('{data: 32'hDEAD_BEEF, some: 1'b0, err: 1'b0});
    issue(3'd5, 32'h0, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (cyc != 2) begin
      failures++;
      $display("FAIL read_latency: %0d cycles, required 2", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_data, cmd_ready, busy} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL read_stall s%0d: rv=%b data=%h ready=%b busy=%b, required 1 DEADBEEF 0 1",
                 i, rsp_valid, rsp_data, cmd_ready, busy);
      end
      step();
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL read_rsp: data=%h some=%b err=%b, required %h %b %b",
                 rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL read_handshake: rv=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_illegal();
    exp_q.push_back('{data: 32'h0, some: 1'b0, err: 1'b1});
    some = 1'b1;
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({rsp_valid, perform_search, set, select_first, write_lines} !== {1'b1, 3'b000, 64'h0}) begin
      failures++;
      $display("FAIL illegal_timing: rv=%b ps=%b set=%b sel=%b wl=%h, required rv=1 rest 0",
               rsp_valid, perform_search, set, select_first, write_lines);
    end
    if (rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL illegal_rsp: data=%h some=%b err=%b, required %h %b %b",
                 rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    rsp_ready = 1'b1;
    exp_q.push_back('{data: 32'h0, some: 1'b0, err: 1'b1});
    issue(3'd6, 32'h1234_5678, 32'h0);
    wait_rsp(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (cyc != 1 || {rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL b2b_illegal: lat=%0d data=%h some=%b err=%b, required lat=1 %h %b %b",
                 cyc, rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    step();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_nostall: rv=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
    some = 1'b0;
    exp_q.push_back('{data: 32'h0, some: 1'b0, err: 1'b0});
    issue(3'd3, 32'h0, 32'h0);
    checks++;
    if (select_first !== 1'b1) begin
      failures++;
      $display("FAIL b2b_select_strobe: sel=%b, required 1", select_first);
    end
    wait_rsp(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (cyc != 2 || {rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL b2b_select: lat=%0d data=%h some=%b err=%b, required lat=2 %h %b %b",
                 cyc, rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_select_done: rv=%b ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    some = 1'b1;
    exp_q.push_back('{data: 32'h0, some: 1'b1, err: 1'b0});
    issue(3'd2, 32'h0, 32'h0);
    step();
    RST = 1'b1;
    step();
    exp_q.delete();
    checks++;
    if ({perform_search, set, select_first, rsp_valid, comparand, mask, busy, write_lines} !== '0) begin
      failures++;
      $display("FAIL abort_state: ps=%b set=%b sel=%b rv=%b cmp=%h mask=%h busy=%b, required all 0",
               perform_search, set, select_first, rsp_valid, comparand, mask, busy);
    end
    RST = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_release: ready=%b, required 1", cmd_ready);
    end
    exp_q.push_back('{data: 32'h0, some: 1'b1, err: 1'b0});
    issue(3'd3, 32'h0, 32'h0);
    checks++;
    if ({perform_search, set, select_first} !== 3'b001) begin
      failures++;
      $display("FAIL abort_select_strobe: {ps,set,sel}=%b, required 001",
               {perform_search, set, select_first});
    end
    wait_rsp(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (cyc != 2 || {rsp_data, rsp_some, rsp_err} !== e) begin
        failures++;
        $display("FAIL abort_select_rsp: lat=%0d data=%h some=%b err=%b, required lat=2 %h %b %b",
                 cyc, rsp_data, rsp_some, rsp_err, e.data, e.some, e.err);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_search(1'b1);
    test_search(1'b0);
    test_write();
    test_read_stall();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
